instruction_sequencer: RTL
==========================

# instruction_sequencer

Upstream feeder for the `cpu` block. A host loads a program of 16-bit instruction words into this block. The block then drives `cpu.current_instruction` one word per clock. It holds off with NOPs while a tensor-core operation completes, and passes burst-write payload words through verbatim. It captures `cpu_output` for generic reads and burst reads into a result FIFO that the host drains.

## Interface
Parameters:
- `PROGRAM_DEPTH`, 32: instruction buffer entries; power of two.
- `RESULT_DEPTH`, 16: result FIFO entries; power of two, ≥ 9.
- `OPERATE_WAIT`, 5: NOP cycles emitted after an operate instruction.
- `BURST_WRITE_WORDS`, 5: payload words following a burst-write header.
- `BURST_READ_WORDS`, 9: cycles sampled after a burst-read header.

Ports:
- `clock_in` in 1: single clock, posedge.
- `reset_in` in 1: synchronous, active-high.
- `host_write_valid_in` in 1: program word valid.
- `host_write_instruction_in` in 16: program word.
- `host_write_ready_out` out 1: buffer accepts a word (IDLE and not full).
- `start_in` in 1: begin execution from entry 0.
- `busy_out` out 1: high in any state other than IDLE.
- `done_out` out 1: one-cycle pulse when the program completes.
- `instruction_out` out 16: to `cpu.current_instruction`.
- `cpu_output_in` in signed 8: from `cpu.cpu_output`.
- `result_valid_out` out 1: FIFO non-empty.
- `result_data_out` out signed 8: FIFO head.
- `result_ready_in` in 1: pop when valid.

## Operation
- Decode uses `instr[1:0]` as the opcode: 00 generic, 01 load immediate, 10 operate, 11 burst. Generic opselect is `[3:2]`; the burst R/W bit is `[2]` (1 = write).
- Loading happens only in IDLE. Each valid&ready handshake writes `buffer[length]` and increments `length`. `length` saturates at `PROGRAM_DEPTH`, at which point ready is low.
- `start_in` is honoured in IDLE only, and only when `length` is nonzero. It sets `pc` to 0 and moves to ISSUE. A start with `length` of 0 pulses `done_out` next cycle and stays in IDLE. A start while busy is ignored.
- States: IDLE, ISSUE, BW_DATA, BR_CAPTURE, OP_WAIT, DONE.
- ISSUE: `instruction_out` is `buffer[pc]`; `pc` increments. The next state is chosen by the decoded opcode:
  - burst write: go to BW_DATA with counter = `BURST_WRITE_WORDS`.
  - burst read: go to BR_CAPTURE with counter = `BURST_READ_WORDS`.
  - operate: go to OP_WAIT with counter = `OPERATE_WAIT`.
  - generic read (opselect 10): push `cpu_output_in` at the closing edge.
  - all others: stay in ISSUE.
  - After the last word, go to DONE.
- Space hold: a burst-read header is not issued until the FIFO has ≥ 9 free entries. A generic read is not issued until there is ≥ 1 free entry. While holding, emit `0x0000` and leave `pc` unchanged.
- BW_DATA: emit `buffer[pc]` verbatim with no decode, increment `pc`, decrement the counter, and return to ISSUE at 0. If the program ends early, emit `0x0000` for the remaining payload cycles, then go to DONE.
- BR_CAPTURE: emit `0x0000` and push `cpu_output_in` every cycle for 9 cycles, then go to ISSUE or DONE.
- OP_WAIT: emit `0x0000` for the counter's duration, then go to ISSUE or DONE.
- DONE: emit `0x0000`, pulse `done_out` for one cycle, return to IDLE. `length` is retained, so `start_in` re-runs the same program.
- A generic reset instruction (`0x000C` low nibble) is passed through like any other word and has no effect on the sequencer.
- Result FIFO: a simultaneous push and pop while full is allowed. A pop while empty is ignored. A push while full cannot occur because of the space hold.

## Timing
- `reset_in`: state IDLE; `pc`, `length`, counters and FIFO cleared. Outputs: `instruction_out` 0x0000, `busy_out` 0, `done_out` 0, `result_valid_out` 0, `result_data_out` 0, `host_write_ready_out` 1. Reset mid-run abandons the run immediately.
- `instruction_out` is registered and changes only on posedge. A word drives `cpu` for exactly one full cycle.
- Start latency: `start_in` at edge N puts `buffer[0]` on `instruction_out` at edge N+1.
- Burst read: header present in cycle T. Samples are taken at the closing edges of cycles T+1 through T+9 (cpu index 0 through 8).
- Generic read: sample at the closing edge of the issue cycle, since `cpu_output` is combinational.
- `result_valid_out` rises the cycle after a push into an empty FIFO.

## Structure
- `tiny_tensor_core_pkg` holds the opcode, opselect and burst-select localparams and the `seq_state_t` enum. `cpu` shares these constants.
- One sub-module, `result_fifo`: synchronous FIFO, parameterised width and depth, with full/empty and a free-count output.

## Test plan
- Load `0x0029, 0x0801, 0x0002`, then start:
  - `instruction_out` sequence is 0x0029, 0x0801, 0x0002, then five 0x0000.
  - `done_out` pulses on the cycle after the last NOP.
- Generic read `0x0808` with `cpu_output_in` = -3: FIFO pops 0xFD.
- Burst-read header `0x0003` with `cpu_output_in` ramping 1 to 9: FIFO yields 1..9 in order.
  - Pre-fill 8 results and repeat: header held as NOPs until the host pops 1.
- Burst-write header `0x0007` followed by 5 payload words such as `0x0001` (opcode 01 in low bits): all 5 emitted verbatim with no OP_WAIT or other decode.
- Assert `reset_in` during BR_CAPTURE after 4 samples: next cycle IDLE, FIFO empty, `instruction_out` 0x0000, `length` 0.
- Host writes 33 words at `PROGRAM_DEPTH` 32: 33rd not accepted (ready low); `start_in` while busy has no effect.

Source files
------------

// File: rtl/tiny_tensor_core_pkg.sv
// Shared instruction-encoding constants and sequencer state type for the
// tiny tensor core (cpu + instruction_sequencer).
package tiny_tensor_core_pkg;

    // Opcode field, instr[1:0]
    localparam logic [1:0] OPC_GENERIC  = 2'b00;
    localparam logic [1:0] OPC_LOAD_IMM = 2'b01;
    localparam logic [1:0] OPC_OPERATE  = 2'b10;
    localparam logic [1:0] OPC_BURST    = 2'b11;

    // Generic-instruction opselect field, instr[3:2]
    localparam logic [1:0] OPSEL_READ  = 2'b10;
    localparam logic [1:0] OPSEL_RESET = 2'b11;

    // Burst direction bit, instr[2]
    localparam logic BURST_SEL_READ  = 1'b0;
    localparam logic BURST_SEL_WRITE = 1'b1;

    // Word driven to the cpu whenever nothing is being issued
    localparam logic [15:0] NOP_WORD = 16'h0000;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_ISSUE,
        SEQ_BW_DATA,
        SEQ_BR_CAPTURE,
        SEQ_OP_WAIT,
        SEQ_DONE
    } seq_state_t;

endpackage

// File: rtl/result_fifo.sv
// Synchronous FIFO with first-word-fall-through head, full/empty flags and a
// free-entry count used by the sequencer to reserve space before reads.
module result_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clock_in,
    input  logic             reset_in,
    input  logic             push_valid_in,
    input  logic [WIDTH-1:0] push_data_in,
    input  logic             pop_ready_in,
    output logic [WIDTH-1:0] pop_data_out,
    output logic             full_out,
    output logic             empty_out,
    output logic [AW:0]      free_count_out
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             push_en;
    logic             pop_en;

    // A pop frees a slot in the same cycle, so push while full is legal with a pop
    assign pop_en  = pop_ready_in && !empty_out;
    assign push_en = push_valid_in && (!full_out || pop_en);

    assign full_out       = (count_reg == (AW+1)'(DEPTH));
    assign empty_out      = (count_reg == '0);
    assign free_count_out = (AW+1)'(DEPTH) - count_reg;
    // Head reads as zero while empty so the output is defined after reset
    assign pop_data_out   = empty_out ? '0 : mem[rd_ptr_reg];

    // Storage write port
    always_ff @(posedge clock_in) begin
        if (push_en) begin
            mem[wr_ptr_reg] <= push_data_in;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_en) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push_en, pop_en})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/instruction_sequencer.sv
// Program buffer and issue engine feeding cpu.current_instruction one word per
// clock, with NOP hold-offs for operate/burst-read and result capture to a FIFO.
module instruction_sequencer
    import tiny_tensor_core_pkg::*;
#(
    parameter int PROGRAM_DEPTH     = 32,
    parameter int RESULT_DEPTH      = 16,
    parameter int OPERATE_WAIT      = 5,
    parameter int BURST_WRITE_WORDS = 5,
    parameter int BURST_READ_WORDS  = 9
) (
    input  logic              clock_in,
    input  logic              reset_in,
    input  logic              host_write_valid_in,
    input  logic [15:0]       host_write_instruction_in,
    output logic              host_write_ready_out,
    input  logic              start_in,
    output logic              busy_out,
    output logic              done_out,
    output logic [15:0]       instruction_out,
    input  logic signed [7:0] cpu_output_in,
    output logic              result_valid_out,
    output logic signed [7:0] result_data_out,
    input  logic              result_ready_in
);

    localparam int PAW   = $clog2(PROGRAM_DEPTH);
    localparam int RAW   = $clog2(RESULT_DEPTH);
    localparam int CNT_W = 8;

    logic [15:0]      buffer [PROGRAM_DEPTH];

    seq_state_t       state_reg,   state_next;
    logic [PAW:0]     pc_reg,      pc_next;
    logic [PAW:0]     length_reg,  length_next;
    logic [CNT_W-1:0] counter_reg, counter_next;
    logic [15:0]      instr_reg,   instr_next;
    logic             sample_reg,  sample_next;
    logic             done_reg,    done_next;

    logic [15:0]      cur_word;
    logic [PAW:0]     pc_inc;
    logic             load_fire;
    logic             is_burst_write;
    logic             is_burst_read;
    logic             is_operate;
    logic             is_generic_read;
    logic             fifo_full;
    logic             fifo_empty;
    logic [RAW:0]     fifo_free;
    logic [RAW:0]     free_eff;
    logic             burst_read_room;
    logic             read_room;
    logic             issue_hold;

    assign host_write_ready_out = (state_reg == SEQ_IDLE) &&
                                  (length_reg != (PAW+1)'(PROGRAM_DEPTH));
    assign load_fire = host_write_valid_in && host_write_ready_out;

    assign cur_word = buffer[pc_reg[PAW-1:0]];
    assign pc_inc   = pc_reg + 1'b1;

    assign is_burst_write  = (cur_word[1:0] == OPC_BURST) && (cur_word[2] == BURST_SEL_WRITE);
    assign is_burst_read   = (cur_word[1:0] == OPC_BURST) && (cur_word[2] == BURST_SEL_READ);
    assign is_operate      = (cur_word[1:0] == OPC_OPERATE);
    assign is_generic_read = (cur_word[1:0] == OPC_GENERIC) && (cur_word[3:2] == OPSEL_READ);

    // A sample already scheduled for the next edge still occupies a slot
    assign free_eff        = fifo_free - (RAW+1)'(sample_reg);
    assign burst_read_room = (free_eff >= (RAW+1)'(BURST_READ_WORDS));
    assign read_room       = !fifo_full && (free_eff != '0);
    assign issue_hold      = (is_burst_read && !burst_read_room) ||
                             (is_generic_read && !read_room);

    assign busy_out         = (state_reg != SEQ_IDLE);
    assign done_out         = done_reg;
    assign instruction_out  = instr_reg;
    assign result_valid_out = !fifo_empty;

    // Program buffer write port, host side
    always_ff @(posedge clock_in) begin
        if (load_fire) begin
            buffer[length_reg[PAW-1:0]] <= host_write_instruction_in;
        end
    end

    // State and datapath registers
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state_reg   <= SEQ_IDLE;
            pc_reg      <= '0;
            length_reg  <= '0;
            counter_reg <= '0;
            instr_reg   <= NOP_WORD;
            sample_reg  <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            length_reg  <= length_next;
            counter_reg <= counter_next;
            instr_reg   <= instr_next;
            sample_reg  <= sample_next;
            done_reg    <= done_next;
        end
    end

    // Next-state, issued word and capture decisions; sample_next marks a word
    // whose cpu response must be captured at the end of its output cycle
    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        length_next  = length_reg;
        counter_next = counter_reg;
        instr_next   = NOP_WORD;
        sample_next  = 1'b0;
        done_next    = 1'b0;

        if (load_fire) begin
            length_next = length_reg + 1'b1;
        end

        case (state_reg)
            SEQ_IDLE: begin
                if (start_in) begin
                    if (length_reg != '0) begin
                        pc_next    = '0;
                        state_next = SEQ_ISSUE;
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end

            SEQ_ISSUE: begin
                if (!issue_hold) begin
                    instr_next = cur_word;
                    pc_next    = pc_inc;
                    if (is_burst_write) begin
                        state_next   = SEQ_BW_DATA;
                        counter_next = CNT_W'(BURST_WRITE_WORDS);
                    end else if (is_burst_read) begin
                        state_next   = SEQ_BR_CAPTURE;
                        counter_next = CNT_W'(BURST_READ_WORDS);
                    end else if (is_operate) begin
                        state_next   = SEQ_OP_WAIT;
                        counter_next = CNT_W'(OPERATE_WAIT);
                    end else begin
                        sample_next = is_generic_read;
                        if (pc_inc == length_reg) begin
                            state_next = SEQ_DONE;
                        end
                    end
                end
            end

            SEQ_BW_DATA: begin
                // Payload is passed through undecoded; pad with NOPs past program end
                if (pc_reg != length_reg) begin
                    instr_next = cur_word;
                    pc_next    = pc_inc;
                end
                counter_next = counter_reg - 1'b1;
                if (counter_reg == CNT_W'(1)) begin
                    state_next = (pc_next == length_reg) ? SEQ_DONE : SEQ_ISSUE;
                end
            end

            SEQ_BR_CAPTURE: begin
                sample_next  = 1'b1;
                counter_next = counter_reg - 1'b1;
                if (counter_reg == CNT_W'(1)) begin
                    state_next = (pc_reg == length_reg) ? SEQ_DONE : SEQ_ISSUE;
                end
            end

            SEQ_OP_WAIT: begin
                counter_next = counter_reg - 1'b1;
                if (counter_reg == CNT_W'(1)) begin
                    state_next = (pc_reg == length_reg) ? SEQ_DONE : SEQ_ISSUE;
                end
            end

            SEQ_DONE: begin
                done_next  = 1'b1;
                state_next = SEQ_IDLE;
            end

            default: begin
                state_next = SEQ_IDLE;
            end
        endcase
    end

    result_fifo #(
        .WIDTH (8),
        .DEPTH (RESULT_DEPTH)
    ) u_result_fifo (
        .clock_in       (clock_in),
        .reset_in       (reset_in),
        .push_valid_in  (sample_reg),
        .push_data_in   (cpu_output_in),
        .pop_ready_in   (result_ready_in),
        .pop_data_out   (result_data_out),
        .full_out       (fifo_full),
        .empty_out      (fifo_empty),
        .free_count_out (fifo_free)
    );

endmodule
